// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth checker: gate bit positions,
// run-control state encoding and the golden two-input gate function.
package gate_chk_pkg;

    localparam int GATE_NOT  = 0;
    localparam int GATE_AND  = 1;
    localparam int GATE_OR   = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Expected gate-block outputs for inputs (a,b); bit0 = not(a).
    function automatic logic [6:0] gate_golden(input logic a, input logic b);
        logic [6:0] g;
        g            = '0;
        g[GATE_NOT]  = ~a;
        g[GATE_AND]  = a & b;
        g[GATE_OR]   = a | b;
        g[GATE_NAND] = ~(a & b);
        g[GATE_NOR]  = ~(a | b);
        g[GATE_XOR]  = a ^ b;
        g[GATE_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gate_truth_checker_ref.sv
// Combinational golden model of the two-input basic-gate block.
// Ports: a_i, b_i gate inputs; gold_o expected 7-bit gate outputs.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [6:0] gold_o
);

    assign gold_o = gate_golden(a_i, b_i);

endmodule

// File: rtl/gate_truth_checker.sv
// Self-checking monitor for the basic-gate block with start/done run control.
// Ports: clk/rst, start, in_valid/in_ready handshake, a/b/gate_out sample,
// busy/done/pass status, vec_cnt/err_cnt/cov stats, first_err_* capture.
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_VECS = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic [6:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             first_err_vld,
    output logic [1:0]       first_err_ab,
    output logic [6:0]       first_err_mask
);

    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECS - 1);

    state_e           state_q, state_d;
    logic             drain_q, drain_d;

    logic             s1_vld_q, s1_vld_d;
    logic             s1_a_q, s1_a_d;
    logic             s1_b_q, s1_b_d;
    logic [6:0]       s1_g_q, s1_g_d;

    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic             fe_vld_q, fe_vld_d;
    logic [1:0]       fe_ab_q, fe_ab_d;
    logic [6:0]       fe_mask_q, fe_mask_d;

    logic             xfer;
    logic             run_entry;
    logic [6:0]       gold;
    logic [6:0]       mism;
    logic             mism_any;

    gate_ref_model u_ref (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .gold_o (gold)
    );

    assign xfer      = in_valid && (state_q == RUN);
    assign run_entry = start && ((state_q == IDLE) || (state_q == DONE));
    assign mism      = gold ^ s1_g_q;
    // Case-inequality so an X/Z on gate_out is flagged as a failure.
    assign mism_any  = (s1_g_q !== gold);

    // Run-control FSM; DRAIN is a fixed two cycles to flush S1 and S2.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (xfer && (vec_q == LAST_VEC)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q) state_d = DONE;
                else         drain_d = 1'b1;
            end
            DONE: begin
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // S1 capture and S2 statistics update.
    always_comb begin
        s1_vld_d  = xfer;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_g_d    = s1_g_q;
        vec_d     = vec_q;
        err_d     = err_q;
        cov_d     = cov_q;
        fe_vld_d  = fe_vld_q;
        fe_ab_d   = fe_ab_q;
        fe_mask_d = fe_mask_q;

        if (xfer) begin
            s1_a_d = a;
            s1_b_d = b;
            s1_g_d = gate_out;
            vec_d  = vec_q + 1'b1;
        end

        if (s1_vld_q) begin
            cov_d[{s1_a_q, s1_b_q}] = 1'b1;
            if (mism_any) begin
                if (err_q != '1) err_d = err_q + 1'b1;
                if (!fe_vld_q) begin
                    fe_vld_d  = 1'b1;
                    fe_ab_d   = {s1_a_q, s1_b_q};
                    fe_mask_d = mism;
                end
            end
        end

        if (run_entry) begin
            s1_vld_d  = 1'b0;
            vec_d     = '0;
            err_d     = '0;
            cov_d     = '0;
            fe_vld_d  = 1'b0;
            fe_ab_d   = '0;
            fe_mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_a_q    <= 1'b0;
            s1_b_q    <= 1'b0;
            s1_g_q    <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            cov_q     <= '0;
            fe_vld_q  <= 1'b0;
            fe_ab_q   <= '0;
            fe_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_g_q    <= s1_g_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            cov_q     <= cov_d;
            fe_vld_q  <= fe_vld_d;
            fe_ab_q   <= fe_ab_d;
            fe_mask_q <= fe_mask_d;
        end
    end

    assign in_ready       = (state_q == RUN);
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == '0) && (cov_q == 4'hF);
    assign vec_cnt        = vec_q;
    assign err_cnt        = err_q;
    assign cov            = cov_q;
    assign first_err_vld  = fe_vld_q;
    assign first_err_ab   = fe_ab_q;
    assign first_err_mask = fe_mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: directed runs push expected
// end-of-run results; monitors pop and compare when done rises.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 0, in_valid = 0, a = 0, b = 0;
    logic [6:0] g = '0;
    logic       in_ready, busy, done, pass;
    logic [7:0] vec_cnt, err_cnt;
    logic [3:0] cov;
    logic       fe_vld;
    logic [1:0] fe_ab;
    logic [6:0] fe_mask;

    logic       s_start = 0, s_valid = 0, s_a = 0, s_b = 0;
    logic [6:0] s_g = '0;
    logic       s_ready, s_busy, s_done, s_pass;
    logic [1:0] s_vec, s_err;
    logic [3:0] s_cov;
    logic       s_fvld;
    logic [1:0] s_fab;
    logic [6:0] s_fmask;

    gate_truth_checker u_dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .gate_out(g),
        .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .cov(cov),
        .first_err_vld(fe_vld), .first_err_ab(fe_ab),
        .first_err_mask(fe_mask)
    );

    gate_truth_checker #(.NUM_VECS(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(s_start),
        .in_valid(s_valid), .in_ready(s_ready),
        .a(s_a), .b(s_b), .gate_out(s_g),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_cnt(s_vec), .err_cnt(s_err), .cov(s_cov),
        .first_err_vld(s_fvld), .first_err_ab(s_fab),
        .first_err_mask(s_fmask)
    );

    typedef struct {
        int vec; int err; int cv; int ps;
        int fvld; int fab; int fmask; int dcyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_sat[$];
    exp_t em, es;
    int   total = 0;
    int   bad   = 0;
    int   pcyc  = 0;
    logic done_d = 0, s_done_d = 0;

    // Hand-computed gate_out, {xnor,xor,nor,nand,or,and,not}
    localparam logic [6:0] G00 = 7'b1011001;
    localparam logic [6:0] G01 = 7'b0101101;
    localparam logic [6:0] G10 = 7'b0101100;
    localparam logic [6:0] G11 = 7'b1000110;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        if (done && !done_d) begin
            if (q_main.size() == 0) begin
                chk("main_spurious_done", 1, 0);
            end else begin
                em = q_main.pop_front();
                chk("main_vec", int'(vec_cnt), em.vec);
                chk("main_err", int'(err_cnt), em.err);
                chk("main_cov", int'(cov), em.cv);
                chk("main_pass", int'(pass), em.ps);
                chk("main_fvld", int'(fe_vld), em.fvld);
                chk("main_fab", int'(fe_ab), em.fab);
                chk("main_fmask", int'(fe_mask), em.fmask);
                chk("main_done_cyc", pcyc, em.dcyc);
                chk("main_busy_at_done", int'(busy), 0);
            end
        end
        done_d <= done;
    end

    always @(negedge clk) begin
        if (s_done && !s_done_d) begin
            if (q_sat.size() == 0) begin
                chk("sat_spurious_done", 1, 0);
            end else begin
                es = q_sat.pop_front();
                chk("sat_vec", int'(s_vec), es.vec);
                chk("sat_err", int'(s_err), es.err);
                chk("sat_cov", int'(s_cov), es.cv);
                chk("sat_pass", int'(s_pass), es.ps);
                chk("sat_fvld", int'(s_fvld), es.fvld);
                chk("sat_fab", int'(s_fab), es.fab);
                chk("sat_fmask", int'(s_fmask), es.fmask);
                chk("sat_done_cyc", pcyc, es.dcyc);
            end
        end
        s_done_d <= s_done;
    end

    task automatic wait_main();
        int k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("main_done_timeout", 0, 1);
    endtask

    task automatic wait_sat();
        int k = 0;
        while (!s_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!s_done) chk("sat_done_timeout", 0, 1);
    endtask

    // Vector i sits at abv[2i+:2] and gv[7i+:7].
    task automatic run_main(input logic [7:0] abv, input logic [27:0] gv,
                            input exp_t e, input bit ce);
        @(negedge clk);
        start  = 1'b1;
        e.dcyc = pcyc + 7;
        q_main.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (ce) begin
            chk("entry_vec", int'(vec_cnt), 0);
            chk("entry_err", int'(err_cnt), 0);
            chk("entry_cov", int'(cov), 0);
            chk("entry_fvld", int'(fe_vld), 0);
        end
        for (int i = 0; i < 4; i++) begin
            {a, b}   = abv[2*i +: 2];
            g        = gv[7*i +: 7];
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_main();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   s;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_outs", int'({vec_cnt, err_cnt, cov, fe_vld, fe_ab, fe_mask}), 0);

        // In IDLE, valid is dropped
        in_valid = 1'b1;
        {a, b}   = 2'b11;
        g        = 7'h00;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_drop_vec", int'(vec_cnt), 0);
        chk("idle_drop_cov", int'(cov), 0);

        e = '{4, 0, 15, 1, 0, 0, 0, 0};
        run_main({2'b11, 2'b10, 2'b01, 2'b00},
                 {G11, G10, G01, G00}, e, 1'b0);

        e = '{4, 1, 15, 0, 1, 2, 32, 0};
        run_main({2'b11, 2'b10, 2'b01, 2'b00},
                 {G11, 7'b0001100, G01, G00}, e, 1'b1);

        e = '{4, 0, 8, 0, 0, 0, 0, 0};
        run_main({2'b11, 2'b11, 2'b11, 2'b11},
                 {G11, G11, G11, G11}, e, 1'b1);

        // Abort with rst; start mid-run must not clear
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        {a, b}   = 2'b00;
        g        = G00;
        @(negedge clk);
        {a, b} = 2'b01;
        g      = G01;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("run_start_ignored_vec", int'(vec_cnt), 2);
        chk("run_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs", int'({vec_cnt, err_cnt, cov, fe_vld, fe_ab, fe_mask}), 0);
        chk("abort_ready", int'(in_ready), 0);
        chk("abort_busy", int'(busy | done | pass), 0);
        rst = 1'b0;
        @(negedge clk);

        // Narrow-counter instance, every vector wrong
        s_start = 1'b1;
        s = pcyc;
        q_sat.push_back('{3, 3, 7, 0, 1, 0, 127, s + 6});
        @(negedge clk);
        s_start = 1'b0;
        s_valid = 1'b1;
        {s_a, s_b} = 2'b00; s_g = ~G00;
        @(negedge clk);
        {s_a, s_b} = 2'b01; s_g = ~G01;
        @(negedge clk);
        {s_a, s_b} = 2'b10; s_g = ~G10;
        @(negedge clk);
        s_valid = 1'b0;
        wait_sat();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("sat_entry_err", int'(s_err), 0);
        chk("sat_entry_fvld", int'(s_fvld), 0);
        chk("sat_entry_ready", int'(s_ready), 1);

        @(negedge clk);
        chk("sb_main_empty", q_main.size(), 0);
        chk("sb_sat_empty", q_sat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
